// File: rtl/rat_alu_pkg.sv
// Shared types for the ALU/flag unit: operation codes, data width and flag pair.
package rat_alu_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_ADDC = 4'd1,
        OP_SUB  = 4'd2,
        OP_SUBC = 4'd3,
        OP_CMP  = 4'd4,
        OP_AND  = 4'd5,
        OP_OR   = 4'd6,
        OP_EXOR = 4'd7,
        OP_TEST = 4'd8,
        OP_LSL  = 4'd9,
        OP_LSR  = 4'd10,
        OP_ROL  = 4'd11,
        OP_ROR  = 4'd12,
        OP_ASR  = 4'd13,
        OP_MOV  = 4'd14,
        OP_RSVD = 4'd15
    } alu_op_t;

    typedef struct packed {
        logic c;
        logic z;
    } flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result, next carry/borrow and next zero from A, B, op and carry-in.
module alu_core
    import rat_alu_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  alu_op_t           op_i,
    input  logic              cin_i,
    output logic [DATA_W-1:0] result_o,
    output logic              cout_o,
    output logic              zout_o
);

    logic [DATA_W:0] wide;

    always_comb begin
        wide     = '0;
        result_o = '0;
        cout_o   = cin_i;
        unique case (op_i)
            OP_ADD: begin
                wide     = {1'b0, a_i} + {1'b0, b_i};
                result_o = wide[DATA_W-1:0];
                cout_o   = wide[DATA_W];
            end
            OP_ADDC: begin
                wide     = {1'b0, a_i} + {1'b0, b_i} + {{DATA_W{1'b0}}, cin_i};
                result_o = wide[DATA_W-1:0];
                cout_o   = wide[DATA_W];
            end
            // Bit 8 of the 9-bit difference is the borrow out.
            OP_SUB, OP_CMP: begin
                wide     = {1'b0, a_i} - {1'b0, b_i};
                result_o = wide[DATA_W-1:0];
                cout_o   = wide[DATA_W];
            end
            OP_SUBC: begin
                wide     = {1'b0, a_i} - {1'b0, b_i} - {{DATA_W{1'b0}}, cin_i};
                result_o = wide[DATA_W-1:0];
                cout_o   = wide[DATA_W];
            end
            OP_AND:  begin result_o = a_i & b_i; cout_o = 1'b0; end
            OP_OR:   begin result_o = a_i | b_i; cout_o = 1'b0; end
            OP_EXOR: begin result_o = a_i ^ b_i; cout_o = 1'b0; end
            OP_TEST: begin result_o = a_i & b_i; cout_o = 1'b0; end
            OP_LSL:  begin result_o = {a_i[DATA_W-2:0], cin_i};          cout_o = a_i[DATA_W-1]; end
            OP_LSR:  begin result_o = {cin_i, a_i[DATA_W-1:1]};          cout_o = a_i[0];        end
            OP_ROL:  begin result_o = {a_i[DATA_W-2:0], a_i[DATA_W-1]};  cout_o = a_i[DATA_W-1]; end
            OP_ROR:  begin result_o = {a_i[0], a_i[DATA_W-1:1]};         cout_o = a_i[0];        end
            OP_ASR:  begin result_o = {a_i[DATA_W-1], a_i[DATA_W-1:1]};  cout_o = a_i[0];        end
            OP_MOV:  begin result_o = b_i;                               cout_o = cin_i;         end
            default: begin result_o = '0;                                cout_o = cin_i;         end
        endcase
    end

    assign zout_o = (result_o == '0);

endmodule

// File: rtl/alu_flag_unit.sv
// ALU with carry/zero flag registers and an interrupt shadow copy of those flags.
// Optional `ALU_OUT_REG_EN registers RESULT (1-cycle latency, resets to 0x00).
module alu_flag_unit
    import rat_alu_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [3:0]        SEL,
    input  logic              FLG_LD,
    input  logic              FLG_LD_SEL,
    input  logic              FLG_C_SET,
    input  logic              FLG_C_CLR,
    input  logic              FLG_SHAD_LD,
    output logic [DATA_W-1:0] RESULT,
    output logic              C_FLAG,
    output logic              Z_FLAG
);

    flags_t            flags_q, flags_d;
    flags_t            shad_q, shad_d;
    flags_t            alu_flags;
    logic [DATA_W-1:0] alu_res;

    alu_core u_core (
        .a_i      (A),
        .b_i      (B),
        .op_i     (alu_op_t'(SEL)),
        .cin_i    (flags_q.c),
        .result_o (alu_res),
        .cout_o   (alu_flags.c),
        .zout_o   (alu_flags.z)
    );

    // A full load (ALU or shadow restore) takes precedence over SET/CLR; CLR beats SET.
    always_comb begin
        flags_d = flags_q;
        if (FLG_LD) begin
            flags_d = FLG_LD_SEL ? shad_q : alu_flags;
        end else if (FLG_C_CLR) begin
            flags_d.c = 1'b0;
        end else if (FLG_C_SET) begin
            flags_d.c = 1'b1;
        end
    end

    always_comb begin
        shad_d = shad_q;
        if (FLG_SHAD_LD) begin
            shad_d = flags_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            flags_q <= '0;
            shad_q  <= '0;
        end else begin
            flags_q <= flags_d;
            shad_q  <= shad_d;
        end
    end

`ifdef ALU_OUT_REG_EN
    logic [DATA_W-1:0] result_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            result_q <= '0;
        end else begin
            result_q <= alu_res;
        end
    end

    assign RESULT = result_q;
`else
    assign RESULT = alu_res;
`endif

    assign C_FLAG = flags_q.c;
    assign Z_FLAG = flags_q.z;

endmodule

// File: tb/tb_alu_flag_unit.sv
// Directed scoreboard bench for alu_flag_unit; follows `ALU_OUT_REG_EN for RESULT timing.
module tb_alu_flag_unit;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] A, B;
    logic [3:0] SEL;
    logic       FLG_LD, FLG_LD_SEL, FLG_C_SET, FLG_C_CLR, FLG_SHAD_LD;
    logic [7:0] RESULT;
    logic       C_FLAG, Z_FLAG;

    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct packed {
        logic [7:0] res;
        logic       c;
        logic       z;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];

    alu_flag_unit dut (
        .CLK         (CLK),
        .RST         (RST),
        .A           (A),
        .B           (B),
        .SEL         (SEL),
        .FLG_LD      (FLG_LD),
        .FLG_LD_SEL  (FLG_LD_SEL),
        .FLG_C_SET   (FLG_C_SET),
        .FLG_C_CLR   (FLG_C_CLR),
        .FLG_SHAD_LD (FLG_SHAD_LD),
        .RESULT      (RESULT),
        .C_FLAG      (C_FLAG),
        .Z_FLAG      (Z_FLAG)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock of stimulus: expected RESULT for the driven inputs, expected flags after the edge.
    task automatic step(input string tag, input logic rst,
                        input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                        input logic ld, input logic ldsel, input logic set, input logic clr,
                        input logic shad,
                        input logic [7:0] eres, input logic ec, input logic ez);
        exp_t       e;
        exp_t       got;
        string      t;
        logic [7:0] res_s;
        @(negedge CLK);
        RST = rst; A = a; B = b; SEL = sel;
        FLG_LD = ld; FLG_LD_SEL = ldsel; FLG_C_SET = set; FLG_C_CLR = clr; FLG_SHAD_LD = shad;
        e.res = eres; e.c = ec; e.z = ez;
`ifdef ALU_OUT_REG_EN
        if (rst) e.res = 8'h00;
`endif
        sb_q.push_back(e);
        tag_q.push_back(tag);
        #1 res_s = RESULT;
        @(posedge CLK);
        #1;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
`ifdef ALU_OUT_REG_EN
        got.res = RESULT;
`else
        got.res = res_s;
`endif
        got.c = C_FLAG;
        got.z = Z_FLAG;
        checks++;
        assert (got.res === e.res) else begin
            errors++;
            $error("FAIL %s RESULT: got %02h expected %02h", t, got.res, e.res);
        end
        checks++;
        assert (got.c === e.c) else begin
            errors++;
            $error("FAIL %s C_FLAG: got %b expected %b", t, got.c, e.c);
        end
        checks++;
        assert (got.z === e.z) else begin
            errors++;
            $error("FAIL %s Z_FLAG: got %b expected %b", t, got.z, e.z);
        end
    endtask

    initial begin
        RST = 1'b1; A = '0; B = '0; SEL = '0;
        FLG_LD = 0; FLG_LD_SEL = 0; FLG_C_SET = 0; FLG_C_CLR = 0; FLG_SHAD_LD = 0;

        //    tag            rst  A      B      SEL   ld ls st cl sh  res    C  Z
        step("reset",        1, 8'h00, 8'h00, 4'd0,  0, 0, 0, 0, 0, 8'h00, 0, 0);
        step("add_ovf",      0, 8'hFF, 8'h01, 4'd0,  1, 0, 0, 0, 0, 8'h00, 1, 1);
        step("addc",         0, 8'h10, 8'h20, 4'd1,  1, 0, 0, 0, 0, 8'h31, 0, 0);
        step("sub_borrow",   0, 8'h05, 8'h07, 4'd2,  1, 0, 0, 0, 0, 8'hFE, 1, 0);
        step("cmp_eq",       0, 8'h42, 8'h42, 4'd4,  1, 0, 0, 0, 0, 8'h00, 0, 1);
        step("sec",          0, 8'h00, 8'h33, 4'd14, 0, 0, 1, 0, 0, 8'h33, 1, 1);
        step("lsl",          0, 8'h80, 8'h00, 4'd9,  1, 0, 0, 0, 0, 8'h01, 1, 0);
        step("ror",          0, 8'h01, 8'h00, 4'd12, 1, 0, 0, 0, 0, 8'h80, 1, 0);
        step("asr",          0, 8'h81, 8'h00, 4'd13, 1, 0, 0, 0, 0, 8'hC0, 1, 0);
        step("lsr",          0, 8'h02, 8'h00, 4'd10, 1, 0, 0, 0, 0, 8'h81, 0, 0);
        step("rol",          0, 8'h80, 8'h00, 4'd11, 1, 0, 0, 0, 0, 8'h01, 1, 0);
        step("subc",         0, 8'h10, 8'h0F, 4'd3,  1, 0, 0, 0, 0, 8'h00, 0, 1);
        step("exor",         0, 8'hAA, 8'hFF, 4'd7,  1, 0, 0, 0, 0, 8'h55, 0, 0);
        step("or_zero",      0, 8'h00, 8'h00, 4'd6,  1, 0, 0, 0, 0, 8'h00, 0, 1);
        step("sec2",         0, 8'h12, 8'h34, 4'd15, 0, 0, 1, 0, 0, 8'h00, 1, 1);
        step("reserved",     0, 8'h12, 8'h34, 4'd15, 1, 0, 0, 0, 0, 8'h00, 1, 1);
        step("mov",          0, 8'h00, 8'h7E, 4'd14, 1, 0, 0, 0, 0, 8'h7E, 1, 0);
        step("test",         0, 8'hF0, 8'h0F, 4'd8,  1, 0, 0, 0, 0, 8'h00, 0, 1);
        // Shadow save / restore
        step("sh_prep",      0, 8'h01, 8'h02, 4'd2,  1, 0, 0, 0, 0, 8'hFF, 1, 0);
        step("sh_save",      0, 8'h00, 8'h05, 4'd14, 0, 0, 0, 0, 1, 8'h05, 1, 0);
        step("clc",          0, 8'h00, 8'h05, 4'd14, 0, 0, 0, 1, 0, 8'h05, 0, 0);
        step("and_zero",     0, 8'h0F, 8'hF0, 4'd5,  1, 0, 0, 0, 0, 8'h00, 0, 1);
        step("restore",      0, 8'h01, 8'h01, 4'd0,  1, 1, 0, 0, 0, 8'h02, 1, 0);
        step("set_clr",      0, 8'h01, 8'h01, 4'd0,  0, 0, 1, 1, 0, 8'h02, 0, 0);
        // Load-vs-strobe priority and concurrent shadow capture
        step("sec3",         0, 8'h00, 8'h00, 4'd14, 0, 0, 1, 0, 0, 8'h00, 1, 0);
        step("ld_over_clr",  0, 8'h80, 8'h80, 4'd0,  1, 0, 0, 1, 1, 8'h00, 1, 1);
        step("restore_old",  0, 8'h00, 8'h00, 4'd14, 1, 1, 1, 0, 0, 8'h00, 1, 0);
        step("clc2",         0, 8'h00, 8'h00, 4'd14, 0, 0, 0, 1, 0, 8'h00, 0, 0);
        step("restore_again",0, 8'h00, 8'h00, 4'd14, 1, 1, 0, 0, 0, 8'h00, 1, 0);
        // Reset in the middle of activity
        step("rst_prep",     0, 8'hFF, 8'h01, 4'd0,  1, 0, 0, 0, 0, 8'h00, 1, 1);
        step("rst_shad",     0, 8'h00, 8'h09, 4'd14, 0, 0, 0, 0, 1, 8'h09, 1, 1);
        step("rst_mid",      1, 8'h55, 8'h01, 4'd0,  1, 0, 1, 0, 1, 8'h56, 0, 0);
        step("post_rst_z",   0, 8'h00, 8'h00, 4'd0,  1, 0, 0, 0, 0, 8'h00, 0, 1);
        step("post_rst_sec", 0, 8'h00, 8'h00, 4'd14, 0, 0, 1, 0, 0, 8'h00, 1, 1);
        step("shadow_reset", 0, 8'h00, 8'h00, 4'd14, 1, 1, 0, 0, 0, 8'h00, 0, 0);

        @(negedge CLK);
        FLG_LD = 0; FLG_LD_SEL = 0; FLG_C_SET = 0; FLG_C_CLR = 0; FLG_SHAD_LD = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
